// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter family:
// FSM state encoding and the bit-counter sizing rule.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Pure combinational add-3 correction.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter. One operand bit is consumed
// per clock, so a conversion takes WIDTH SHIFT cycles followed by one DONE cycle.
// Digits that do not fit in DIGITS decades are dropped and reported through ovf.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIDTH-1:0]    binary,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                neg,
    output logic                ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam int BW = 4 * DIGITS;

    localparam logic [WIDTH-1:0] MAG_ONE  = WIDTH'(1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  opnd_q, opnd_d;
    logic [BW-1:0]     dig_q, dig_d;
    logic              sign_q, sign_d;
    logic              wovf_q, wovf_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;

    logic [BW-1:0]     dig_adj;
    logic [BW-1:0]     dig_shift;
    logic [WIDTH-1:0]  opnd_shift;
    logic              carry_out;
    logic              in_neg;
    logic [WIDTH-1:0]  in_mag;

    // One add-3 corrector per working digit.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig_q[4*gi +: 4]),
            .dout (dig_adj[4*gi +: 4])
        );
    end

    // One double-dabble step: shift {digits, operand} left, catching the bit
    // that falls off the top digit as an overflow indication.
    always_comb begin
        dig_shift  = {dig_adj[BW-2:0], opnd_q[WIDTH-1]};
        opnd_shift = {opnd_q[WIDTH-2:0], 1'b0};
        carry_out  = dig_adj[BW-1];
    end

    // Operand magnitude; two's-complement negation of the most negative value
    // yields 2^(WIDTH-1), which is exact when read as unsigned.
    always_comb begin
        in_neg = (SIGNED != 0) && binary[WIDTH-1];
        in_mag = binary;
        if (in_neg) begin
            in_mag = ~binary + MAG_ONE;
        end
    end

    // Next-state and datapath update for the IDLE/SHIFT/DONE controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        dig_d   = dig_q;
        sign_d  = sign_q;
        wovf_d  = wovf_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    opnd_d  = in_mag;
                    sign_d  = in_neg;
                    dig_d   = '0;
                    wovf_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                dig_d  = dig_shift;
                opnd_d = opnd_shift;
                wovf_d = wovf_q | carry_out;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                    bcd_d   = dig_shift;
                    neg_d   = sign_q;
                    ovf_d   = wovf_q | carry_out;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state lives here; reset wins over any pending start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            dig_q   <= '0;
            sign_q  <= 1'b0;
            wovf_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            dig_q   <= dig_d;
            sign_q  <= sign_d;
            wovf_q  <= wovf_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign bcd  = bcd_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: four configurations side by side, randomized operands
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_v;
    logic [31:0] bin_v;
    logic [3:0]  busy_v, done_v, neg_v, ovf_v;
    logic [11:0] bcd0, bcd1;
    logic [7:0]  bcd2;
    logic [15:0] bcd3;
    logic [15:0] bcd_v [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign bcd_v[0] = {4'h0, bcd0};
    assign bcd_v[1] = {4'h0, bcd1};
    assign bcd_v[2] = {8'h00, bcd2};
    assign bcd_v[3] = bcd3;

    // 0: 8-bit unsigned, 3 digits
    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u_u8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .binary(bin_v[7:0]),
        .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd0), .neg(neg_v[0]), .ovf(ovf_v[0]));
    // 1: 8-bit signed, 3 digits
    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u_s8 (
        .clk(clk), .rst(rst), .start(start_v[1]), .binary(bin_v[7:0]),
        .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd1), .neg(neg_v[1]), .ovf(ovf_v[1]));
    // 2: 8-bit unsigned, 2 digits
    bin2bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u_d2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .binary(bin_v[7:0]),
        .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd2), .neg(neg_v[2]), .ovf(ovf_v[2]));
    // 3: 10-bit unsigned, 4 digits
    bin2bcd_seq #(.WIDTH(10), .DIGITS(4), .SIGNED(0)) u_w10 (
        .clk(clk), .rst(rst), .start(start_v[3]), .binary(bin_v[9:0]),
        .busy(busy_v[3]), .done(done_v[3]), .bcd(bcd3), .neg(neg_v[3]), .ovf(ovf_v[3]));

    function automatic int cfg_width(input int sel);
        return (sel == 3) ? 10 : 8;
    endfunction

    function automatic int cfg_digits(input int sel);
        case (sel)
            2:       return 2;
            3:       return 4;
            default: return 3;
        endcase
    endfunction

    // Signed value of the operand as the instance interprets it.
    function automatic longint ref_value(input int sel, input logic [31:0] v);
        logic [7:0] b8;
        b8 = v[7:0];
        if (sel == 1) return longint'($signed(b8));
        if (sel == 3) return longint'(v[9:0]);
        return longint'(b8);
    endfunction

    function automatic longint ref_mag(input int sel, input logic [31:0] v);
        longint x;
        x = ref_value(sel, v);
        return (x < 0) ? -x : x;
    endfunction

    // Decimal digits of (mag mod 10^digits), ones digit in the low nibble.
    function automatic logic [15:0] ref_bcd(input longint mag, input int digits);
        logic [15:0] r;
        longint m;
        r = '0;
        m = mag;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint mag, input int digits);
        longint lim;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        return mag > (lim - 1);
    endfunction

    // Issue one start pulse and follow the conversion to its done cycle.
    // Returns at the sampling point of the done cycle; lat counts edges after
    // the accepting edge, busy_cnt counts busy cycles before done.
    task automatic run_conv(input int sel, input logic [31:0] val,
                            output logic [15:0] bcd_o, output logic neg_o,
                            output logic ovf_o, output int lat, output int busy_cnt,
                            output bit timeout);
        @(negedge clk);
        bin_v = val;
        start_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[sel] = 1'b0;
        lat = 0;
        busy_cnt = 0;
        timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done_v[sel]) begin
                timeout = 1'b0;
                break;
            end
            if (busy_v[sel]) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        bcd_o = bcd_v[sel];
        neg_o = neg_v[sel];
        ovf_o = ovf_v[sel];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_v = '0;
        bin_v = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if ({busy_v[s], done_v[s], neg_v[s], ovf_v[s], bcd_v[s]} !== 20'h0) begin
                $display("FAIL reset_state inst%0d: got busy=%b done=%b neg=%b ovf=%b bcd=%h, want all 0",
                         s, busy_v[s], done_v[s], neg_v[s], ovf_v[s], bcd_v[s]);
            end else n_pass++;
        end
        rst = 1'b0;
    endtask

    // Shared check block used by each feature test on one finished conversion.
    task automatic test_convert(input int sel, input logic [31:0] val, input string tag);
        logic [15:0] b, eb;
        logic n, o, en, eo;
        int lat, bc;
        bit to;
        longint mag;
        run_conv(sel, val, b, n, o, lat, bc, to);
        mag = ref_mag(sel, val);
        eb  = ref_bcd(mag, cfg_digits(sel));
        eo  = ref_ovf(mag, cfg_digits(sel));
        en  = ref_value(sel, val) < 0;
        n_checks++;
        if (to) begin
            $display("FAIL %s_done_timeout inst%0d in=%0d: no done within 100 cycles", tag, sel, val);
        end else if (b !== eb || n !== en || o !== eo) begin
            $display("FAIL %s_result inst%0d in=%0d: got bcd=%h neg=%b ovf=%b, want bcd=%h neg=%b ovf=%b",
                     tag, sel, val, b, n, o, eb, en, eo);
        end else n_pass++;
        n_checks++;
        if (lat !== cfg_width(sel) || bc !== cfg_width(sel)) begin
            $display("FAIL %s_latency inst%0d in=%0d: got lat=%0d busy=%0d, want %0d/%0d",
                     tag, sel, val, lat, bc, cfg_width(sel), cfg_width(sel));
        end else n_pass++;
    endtask

    task automatic test_unsigned;
        test_convert(0, 32'd255, "u8_255");
        test_convert(0, 32'd0, "u8_zero");
        for (int i = 0; i < 12; i++) test_convert(0, $urandom_range(255, 0), "u8_rand");
    endtask

    task automatic test_back_to_back;
        logic [15:0] b;
        logic n, o;
        int lat, bc, gap;
        bit to, seen;
        run_conv(0, 32'd0, b, n, o, lat, bc, to);
        n_checks++;
        if (to || b !== 16'h000 || o !== 1'b0) begin
            $display("FAIL b2b_first: got bcd=%h ovf=%b timeout=%b, want bcd=000 ovf=0", b, o, to);
        end else n_pass++;
        // Still in the done cycle: request the next conversion right away.
        bin_v = 32'd99;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        gap = 1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done_v[0]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            gap++;
        end
        n_checks++;
        if (!seen || bcd_v[0] !== 16'h099 || gap !== 9) begin
            $display("FAIL b2b_second: got bcd=%h gap=%0d seen=%b, want bcd=099 gap=9", bcd_v[0], gap, seen);
        end else n_pass++;
    endtask

    task automatic test_signed;
        test_convert(1, 32'h80, "s8_min");
        test_convert(1, 32'hF6, "s8_m10");
        test_convert(1, 32'h7F, "s8_max");
        for (int i = 0; i < 10; i++) test_convert(1, $urandom_range(255, 0), "s8_rand");
    endtask

    task automatic test_overflow;
        test_convert(2, 32'd200, "d2_200");
        test_convert(2, 32'd99, "d2_99");
        test_convert(2, 32'd100, "d2_100");
        for (int i = 0; i < 10; i++) test_convert(2, $urandom_range(255, 0), "d2_rand");
    endtask

    task automatic test_ignore_start;
        int lat;
        bit seen;
        int extra;
        logic [15:0] held;
        @(negedge clk);
        bin_v = 32'd42;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_v[0]) begin
                seen = 1'b1;
                break;
            end
            start_v[0] = (lat == 3);
            if (lat == 3) bin_v = 32'd200;
            @(negedge clk);
            lat++;
        end
        start_v[0] = 1'b0;
        n_checks++;
        if (!seen || bcd_v[0] !== 16'h042 || lat !== 8) begin
            $display("FAIL ignore_start: got bcd=%h lat=%0d seen=%b, want bcd=042 lat=8", bcd_v[0], lat, seen);
        end else n_pass++;
        held = bcd_v[0];
        extra = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done_v[0]) extra++;
        end
        n_checks++;
        if (extra !== 0 || bcd_v[0] !== held) begin
            $display("FAIL done_once_hold: got extra_done=%0d bcd=%h, want 0 and %h", extra, bcd_v[0], held);
        end else n_pass++;
    endtask

    task automatic test_abort;
        int pulses;
        @(negedge clk);
        bin_v = 32'd123;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_v[0]) pulses++;
            @(negedge clk);
        end
        n_checks++;
        if (pulses !== 0 || {busy_v[0], neg_v[0], ovf_v[0], bcd_v[0]} !== 19'h0) begin
            $display("FAIL abort: got done_pulses=%0d busy=%b neg=%b ovf=%b bcd=%h, want 0 and all 0",
                     pulses, busy_v[0], neg_v[0], ovf_v[0], bcd_v[0]);
        end else n_pass++;
        test_convert(0, 32'd77, "after_rst");
    endtask

    task automatic test_sweep;
        for (int v = 0; v < 1024; v++) test_convert(3, 32'(v), "w10_sweep");
    endtask

    initial begin
        rst = 1'b1;
        start_v = '0;
        bin_v = '0;
        test_reset;
        test_unsigned;
        test_back_to_back;
        test_signed;
        test_overflow;
        test_ignore_start;
        test_abort;
        test_sweep;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
